nn_mac_sched: RTL
=================

# nn_mac_sched

Time-multiplexed sequencer for the 4-4-2 inference network. It runs the whole network through one shared signed multiply-accumulate unit instead of 24 parallel multipliers:

- 16 hidden-layer products, with ReLU applied to each hidden sum.
- 8 output-layer products, with no activation on the outputs.

It sits where the parallel `top` datapath sits and drives the same result/ready contract toward the system. One job completes every 25 cycles.

## Interface
Parameters:
- none; all dimensions and widths come from `nn_pkg` (`DW`=5, `HW`=12, `OW`=17, `N_IN`=4, `N_HID`=4, `N_OUT`=2).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_ready`  in  1  job-start strobe; sampled only in `IDLE` or `DONE`
- `x`  in  20  signed inputs; `x[5i+4:5i]` = x_i, i = 0..3
- `w_hid`  in  80  signed weights; `w_hid[5(4j+i)+:5]` = w_i,(4+j), j = 0..3
- `w_out`  in  40  signed weights; `w_out[5(4k+j)+:5]` = w_(4+j),(8+k), k = 0..1
- `out0`, `out1`  out  17 each  signed results, two's complement
- `out0_ready`, `out1_ready`  out  1 each  result-valid levels
- `busy`  out  1  high in `HID` and `OUT`

## Operation
- **Operand capture.** On the accepting edge, `x`, `w_hid` and `w_out` are registered. Inputs may change freely afterwards.
- **Hidden layer:** h_j = ReLU(Σ_i x_i · w_i,(4+j)).
  - All operands are signed 5-bit.
  - Pre-ReLU sums lie in [-1024, +1024]; stored h_j is 12-bit, range 0..1024.
- **Output layer:** out_k = Σ_j h_j · w_(4+j),(8+k).
  - Range is [-65536, +61440], which fits 17-bit signed exactly.
  - No saturation is needed, and none is implemented.
- **MAC term ordering.** One MAC term per cycle:
  - Hidden phase: j outer, i inner.
  - Output phase: k outer, j inner.
  - The first term of each sum loads the accumulator (acc = prod); later terms add (acc = acc + prod).
  - The 4th term writes the stored result directly (acc + prod): to h_j, or to an internal staging register for out_k.
- **FSM states and transitions:**
  - `IDLE`: reset state. `in_ready` → capture operands, clear term counter, go to `HID`.
  - `HID`: 16 cycles; term counter 0..15. After term 15 go to `OUT`.
  - `OUT`: 8 cycles; term counter 0..7. On term 7, copy both staging results to `out0`/`out1`, set both ready flags, go to `DONE`.
  - `DONE`: outputs held. `in_ready` → capture a new job, clear both ready flags on the same edge, go to `HID`. `out0`/`out1` keep their old values until overwritten.
- **`in_ready` while busy.** In `HID`/`OUT` it is ignored: no queuing, no abort.
- **Reset**, including mid-job: state `IDLE`, counter 0, accumulator and h_j 0, `out0`/`out1` = 0, both ready flags 0, `busy` = 0.

## Timing
- Edge E0: `in_ready` sampled high; operands captured; `busy` rises.
- Edges E1..E16: hidden terms.
- Edges E17..E24: output terms.
- E24: `out0`, `out1`, `out0_ready` and `out1_ready` all update together, and `busy` falls. Latency is 24 edges from the accepting edge.
- Ready flags are levels: high from E24 until the next accepting edge or reset. Both flags always change in the same cycle.
- Back-to-back: `in_ready` in the first `DONE` cycle is accepted at E25. The next job therefore starts every 25 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- `nn_pkg` holds:
  - constants `DW`, `HW`, `OW`, `N_IN`, `N_HID`, `N_OUT`;
  - state enum `IDLE`/`HID`/`OUT`/`DONE`;
  - operand-slicing helper functions for the flat buses.
- Sub-module `nn_mac` (combinational):
  - operands: signed 5-bit weight × signed 12-bit value;
  - in the hidden phase the 12-bit operand is x_i, sign-extended;
  - 17-bit product, plus 17-bit add with a load/accumulate select.
- `nn_mac_sched` holds the FSM, term counter, operand muxes, h_j registers, staging registers and output registers.

## Test plan
- **Mixed-sign vector.**
  - x = {4,2,4,1}; w_hid rows j=0..3 = {3,2,13,-6}, {-9,1,-4,14}, {3,6,-15,15}, {9,-10,15,-10}; w_out rows k=0,1 = {0,-1,3,-11}, {-12,-15,-15,6}.
  - Required: `out0` = -726 (0x1FD2A), `out1` = -348 (0x1FEA4), both ready at E24.
- **Non-negative vector.**
  - Same x; w_hid = {3,2,13,0}, {0,0,0,14}, {3,6,0,15}, {9,0,15,0}; w_out = {0,0,3,11}, {12,0,0,6}.
  - Required: h = {68,14,39,96}; `out0` = 1173, `out1` = 1392.
- **Extremes.**
  - All x = -16 and all weights = -16 → h_j = 1024 each, `out0` = `out1` = -65536 (0x10000).
  - Same with all x = +15 → h_j = 0 by ReLU, outputs 0.
- **Busy strobe ignored.** `in_ready` pulsed at E5 with different operands → ignored; the result equals the first job's.
- **Reset mid-job.** `rst` at E10 → next edge: all outputs 0, ready low, `busy` low. A fresh job afterwards produces correct values.
- **Back-to-back jobs.** `in_ready` held high → ready pulses high for exactly 1 cycle (E24 to E25). Second result appears at E49 with new values; `out0`/`out1` keep their old values in between.

Source files
------------

// File: rtl/nn_pkg.sv
// Shared dimensions, FSM state type and flat-bus operand slicing for the
// time-multiplexed 4-4-2 network sequencer.
package nn_pkg;
  localparam int DW    = 5;
  localparam int HW    = 12;
  localparam int OW    = 17;
  localparam int N_IN  = 4;
  localparam int N_HID = 4;
  localparam int N_OUT = 2;
  localparam int XW    = DW * N_IN;
  localparam int WHW   = DW * N_IN * N_HID;
  localparam int WOW   = DW * N_HID * N_OUT;

  typedef enum logic [1:0] {IDLE, HID, OUT, DONE} state_e;

  function automatic logic signed [DW-1:0] slice_x(input logic [XW-1:0] bus,
                                                   input logic [1:0] i);
    return bus[int'(i)*DW +: DW];
  endfunction

  // Hidden weights are laid out so the term counter is the slot index.
  function automatic logic signed [DW-1:0] slice_whid(input logic [WHW-1:0] bus,
                                                      input logic [3:0] idx);
    return bus[int'(idx)*DW +: DW];
  endfunction

  function automatic logic signed [DW-1:0] slice_wout(input logic [WOW-1:0] bus,
                                                      input logic [2:0] idx);
    return bus[int'(idx)*DW +: DW];
  endfunction
endpackage

// File: rtl/nn_mac.sv
// Shared signed MAC: 5-bit weight x 12-bit value, with load/accumulate select.
module nn_mac
  import nn_pkg::*;
(
  input  logic signed [DW-1:0] w,
  input  logic signed [HW-1:0] v,
  input  logic signed [OW-1:0] acc,
  input  logic                 load,
  output logic signed [OW-1:0] sum
);
  logic signed [OW-1:0] w_ext, v_ext, prod;

  always_comb begin
    w_ext = {{(OW-DW){w[DW-1]}}, w};
    v_ext = {{(OW-HW){v[HW-1]}}, v};
    prod  = w_ext * v_ext;
    sum   = load ? prod : acc + prod;
  end
endmodule

// File: rtl/nn_mac_sched.sv
// Runs the 4-4-2 network through one MAC: 16 hidden terms (ReLU), then
// 8 output terms; one job every 25 cycles.
module nn_mac_sched
  import nn_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_ready,
  input  logic [XW-1:0]        x,
  input  logic [WHW-1:0]       w_hid,
  input  logic [WOW-1:0]       w_out,
  output logic signed [OW-1:0] out0,
  output logic signed [OW-1:0] out1,
  output logic                 out0_ready,
  output logic                 out1_ready,
  output logic                 busy
);
  state_e                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [XW-1:0]              x_q, x_d;
  logic [WHW-1:0]             w_hid_q, w_hid_d;
  logic [WOW-1:0]             w_out_q, w_out_d;
  logic signed [OW-1:0]       acc_q, acc_d;
  logic [N_HID-1:0][HW-1:0]   h_q, h_d;
  logic signed [OW-1:0]       stg0_q, stg0_d;
  logic signed [OW-1:0]       out0_q, out0_d, out1_q, out1_d;
  logic                       rdy_q, rdy_d, busy_q, busy_d;

  logic signed [DW-1:0]       mac_w, x_i;
  logic signed [HW-1:0]       mac_v;
  logic signed [OW-1:0]       mac_sum;
  logic                       mac_load, last_term, accept;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_ready)       state_d = HID;
      HID:     if (cnt_q == 4'd15) state_d = OUT;
      OUT:     if (cnt_q == 4'd7)  state_d = DONE;
      DONE:    if (in_ready)       state_d = HID;
      default:                     state_d = IDLE;
    endcase
  end

  // Hidden phase: cnt = {j,i}; output phase: cnt[2:0] = {k,j}.
  always_comb begin
    x_i       = slice_x(x_q, cnt_q[1:0]);
    mac_w     = (state_q == HID) ? slice_whid(w_hid_q, cnt_q)
                                 : slice_wout(w_out_q, cnt_q[2:0]);
    mac_v     = (state_q == HID) ? {{(HW-DW){x_i[DW-1]}}, x_i}
                                 : h_q[cnt_q[1:0]];
    mac_load  = (cnt_q[1:0] == 2'd0);
    last_term = (cnt_q[1:0] == 2'd3);
  end

  nn_mac u_mac (
    .w    (mac_w),
    .v    (mac_v),
    .acc  (acc_q),
    .load (mac_load),
    .sum  (mac_sum)
  );

  always_comb begin
    cnt_d   = cnt_q;
    x_d     = x_q;
    w_hid_d = w_hid_q;
    w_out_d = w_out_q;
    acc_d   = acc_q;
    h_d     = h_q;
    stg0_d  = stg0_q;
    out0_d  = out0_q;
    out1_d  = out1_q;
    rdy_d   = rdy_q;
    accept  = in_ready && (state_q == IDLE || state_q == DONE);
    if (accept) begin
      x_d     = x;
      w_hid_d = w_hid;
      w_out_d = w_out;
      cnt_d   = 4'd0;
      rdy_d   = 1'b0;
    end
    if (state_q == HID) begin
      acc_d = mac_sum;
      cnt_d = 4'(cnt_q + 4'd1);
      if (last_term)
        h_d[cnt_q[3:2]] = mac_sum[OW-1] ? '0 : mac_sum[HW-1:0];
    end
    if (state_q == OUT) begin
      acc_d = mac_sum;
      cnt_d = (cnt_q == 4'd7) ? 4'd0 : 4'(cnt_q + 4'd1);
      if (last_term && !cnt_q[2]) stg0_d = mac_sum;
      // out1's final sum goes straight to the output register.
      if (cnt_q == 4'd7) begin
        out0_d = stg0_q;
        out1_d = mac_sum;
        rdy_d  = 1'b1;
      end
    end
    busy_d = (state_d == HID) || (state_d == OUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      x_q     <= '0;
      w_hid_q <= '0;
      w_out_q <= '0;
      acc_q   <= '0;
      h_q     <= '0;
      stg0_q  <= '0;
      out0_q  <= '0;
      out1_q  <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      w_hid_q <= w_hid_d;
      w_out_q <= w_out_d;
      acc_q   <= acc_d;
      h_q     <= h_d;
      stg0_q  <= stg0_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign out0       = out0_q;
  assign out1       = out1_q;
  assign out0_ready = rdy_q;
  assign out1_ready = rdy_q;
  assign busy       = busy_q;
endmodule
